// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and types for the PE front end.
//   PE_N_ELEM   - elements per 7x7 window
//   PE_DATA_W   - element width (raw FP16 bit pattern)
//   PE_TREE_LAT - register stages between adder-tree input bus and final_sum
//   fp16_t          - one FP16 element
//   packer_state_e  - window packer states (FILL, FULL)
package pe_pkg;

  localparam int PE_N_ELEM   = 49;
  localparam int PE_DATA_W   = 16;
  localparam int PE_TREE_LAT = 6;

  typedef logic [PE_DATA_W-1:0] fp16_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-deep single-bit shift register with asynchronous
// active-low clear. A pulse on 'pulse' in cycle C appears on 'pulse_dly'
// in cycle C+DEPTH.
//   clk       - clock
//   rst_n     - asynchronous active-low clear of every stage
//   pulse     - token entering the line
//   pulse_dly - token leaving the line DEPTH cycles later
module valid_delay_line
  import pe_pkg::*;
#(
  parameter int DEPTH = PE_TREE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic pulse_dly
);

  logic [DEPTH-1:0] shift_r;

  // Shift tokens one stage per cycle; reset drops every in-flight token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
    end else begin
      shift_r <= (shift_r << 1) | DEPTH'(pulse);
    end
  end

  assign pulse_dly = shift_r[DEPTH-1];

endmodule

// File: rtl/fp16_window_packer_49.sv
// fp16_window_packer_49: serial-to-parallel front end for the 49-input FP16
// adder tree. Collects one element per accepted beat into a 49-slot window,
// presents it on a flat bus with valid/ready, and delays the output
// handshake by the tree latency to mark final_sum as valid.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready - element input stream
//   out_flat/out_valid/out_ready      - window output (element k at bits
//                                        [16k+15:16k])
//   sum_valid           - tree final_sum belongs to a handshaken window
//   frame_err           - one-cycle pulse when in_last disagrees with count
//
// Build option: define PACKER_ZERO_PAD_EN to turn an early in_last into a
// zero-padded window instead of a discarded frame.
module fp16_window_packer_49
  import pe_pkg::*;
#(
  parameter int N_ELEM   = PE_N_ELEM,
  parameter int DATA_W   = PE_DATA_W,
  parameter int TREE_LAT = PE_TREE_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DATA_W*N_ELEM-1:0] out_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sum_valid,
  output logic                     frame_err
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

`ifdef PACKER_ZERO_PAD_EN
  localparam logic ZERO_PAD = 1'b1;
`else
  localparam logic ZERO_PAD = 1'b0;
`endif

  typedef logic [N_ELEM-1:0][DATA_W-1:0] window_t;

  packer_state_e    state_r, state_n_s;
  logic [IDX_W-1:0] idx_r, idx_n_s;
  window_t          fill_r;
  window_t          out_flat_r;
  window_t          win_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             frame_err_r;

  logic accept_s;
  logic slot_free_s;
  logic handshake_s;
  logic complete_s;
  logic fill_wr_s;
  logic fill_win_s;
  logic load_win_s;
  logic load_fill_s;
  logic err_s;

  assign accept_s    = in_valid && in_ready_r;
  assign slot_free_s = !out_valid_r || out_ready;
  assign handshake_s = out_valid_r && out_ready;
  // A window closes on the 49th element, or early on in_last when padding.
  assign complete_s  = accept_s && (state_r == FILL) &&
                       ((idx_r == IDX_LAST) || (in_last && ZERO_PAD));

  // Completed window as it would look this cycle: stored slots below idx,
  // the incoming element at idx, +0.0 above idx (only reachable when padding).
  always_comb begin
    win_s = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      if (IDX_W'(k) < idx_r) begin
        win_s[k] = fill_r[k];
      end else if (IDX_W'(k) == idx_r) begin
        win_s[k] = in_data;
      end else begin
        win_s[k] = DATA_W'(0);
      end
    end
  end

  // Next-state and datapath control for the FILL/FULL machine.
  always_comb begin
    state_n_s   = state_r;
    idx_n_s     = idx_r;
    fill_wr_s   = 1'b0;
    fill_win_s  = 1'b0;
    load_win_s  = 1'b0;
    load_fill_s = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      FILL: begin
        if (complete_s) begin
          err_s = (idx_r == IDX_LAST) && !in_last;
          if (slot_free_s) begin
            load_win_s = 1'b1;
            idx_n_s    = '0;
          end else begin
            fill_win_s = 1'b1;
            state_n_s  = FULL;
          end
        end else if (accept_s && in_last) begin
          // Short frame without padding: drop it and start over.
          idx_n_s = '0;
          err_s   = 1'b1;
        end else if (accept_s) begin
          fill_wr_s = 1'b1;
          idx_n_s   = idx_r + IDX_W'(1);
        end else begin
          idx_n_s = idx_r;
        end
      end
      FULL: begin
        if (slot_free_s) begin
          load_fill_s = 1'b1;
          idx_n_s     = '0;
          state_n_s   = FILL;
        end else begin
          state_n_s = FULL;
        end
      end
      default: begin
        state_n_s = FILL;
        idx_n_s   = '0;
      end
    endcase
  end

  // Control registers; in_ready is registered and low whenever FULL is next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      idx_r       <= '0;
      in_ready_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      idx_r       <= idx_n_s;
      in_ready_r  <= (state_n_s == FILL);
      frame_err_r <= err_s;
    end
  end

  // Fill buffer: one slot per accepted beat, or the whole window when parking in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= '0;
    end else if (fill_win_s) begin
      fill_r <= win_s;
    end else if (fill_wr_s) begin
      fill_r[idx_r] <= in_data;
    end else begin
      fill_r <= fill_r;
    end
  end

  // Output slot: load a new window, or drop valid on handshake, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flat_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (load_win_s) begin
      out_flat_r  <= win_s;
      out_valid_r <= 1'b1;
    end else if (load_fill_s) begin
      out_flat_r  <= fill_r;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  valid_delay_line #(
    .DEPTH(TREE_LAT)
  ) u_sum_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse    (handshake_s),
    .pulse_dly(sum_valid)
  );

  assign in_ready  = in_ready_r;
  assign out_flat  = out_flat_r;
  assign out_valid = out_valid_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_fp16_window_packer_49.sv
// tb_fp16_window_packer_49: scoreboard bench for fp16_window_packer_49.
// The driver feeds elements and a window-level model pushes expected windows;
// a negedge monitor pops and compares on every output handshake and checks
// sum_valid timing, hold stability and frame_err counts.
module tb_fp16_window_packer_49;

  localparam int N   = 49;
  localparam int W   = 16;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [W*N-1:0] out_flat;
  logic         out_valid;
  logic         sum_valid;
  logic         frame_err;

  always #5 clk = ~clk;

  fp16_window_packer_49 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_flat (out_flat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_valid(sum_valid),
    .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;
  logic [W*N-1:0] exp_q[$];
  int sum_due[$];
  int hs_cycles[$];
  int cyc = 0;
  int err_exp = 0;
  int err_seen = 0;
  int stalls = 0;
  logic [W-1:0] cur[N];
  int cnt = 0;
  logic prev_hold = 1'b0;
  logic [W*N-1:0] prev_flat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_fp16(input int n);
    int e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 5'(e + 15), 10'((n << (10 - e)) & 32'h3ff)};
  endfunction

  function automatic logic [W*N-1:0] pack_cur();
    logic [W*N-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[W*k +: W] = cur[k];
    return f;
  endfunction

  // Window-level model of one accepted element.
  task automatic model_accept(input logic [W-1:0] d, input logic last);
    if (cnt == N - 1) begin
      cur[cnt] = d;
      exp_q.push_back(pack_cur());
      if (!last) err_exp++;
      cnt = 0;
    end else if (last) begin
`ifdef PACKER_ZERO_PAD_EN
      cur[cnt] = d;
      for (int j = cnt + 1; j < N; j++) cur[j] = 16'h0000;
      exp_q.push_back(pack_cur());
`else
      err_exp++;
`endif
      cnt = 0;
    end else begin
      cur[cnt] = d;
      cnt++;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, input int gap);
    logic acc;
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stalls++;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: element not taken in %0d cycles", t);
    end else begin
      model_accept(d, last);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || sum_due.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 64'(exp_q.size() + sum_due.size()), 64'd0);
  endtask

  // Monitor: scoreboard pop on handshake, sum_valid timing, hold stability.
  always @(negedge clk) begin
    logic exp_s;
    cyc++;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        checks++;
        if (out_flat !== prev_flat) begin
          errors++;
          $display("FAIL hold_flat: out_flat changed while stalled");
        end
      end
      exp_s = (sum_due.size() > 0) && (sum_due[0] == cyc);
      if (exp_s) void'(sum_due.pop_front());
      if (exp_s || sum_valid) check("sum_valid", 64'(sum_valid), 64'(exp_s));
      if (frame_err) err_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL window: unexpected window %h", out_flat);
        end else begin
          logic [W*N-1:0] e;
          e = exp_q.pop_front();
          if (out_flat !== e) begin
            errors++;
            $display("FAIL window: got %h expected %h", out_flat, e);
          end
        end
        hs_cycles.push_back(cyc);
        sum_due.push_back(cyc + LAT);
      end
      prev_hold = out_valid && !out_ready;
      prev_flat = out_flat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_flat_zero", 64'(out_flat == '0), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // All-ones window, streaming consumer.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(16'h3C00, i == N - 1, 0);
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("out_valid_one_cycle", 64'(out_valid), 64'd0);
    drain("drain_ones");

    // Backpressure: window of k+1, then a second window parks in FULL.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(to_fp16(i + 1), i == N - 1, 0);
    for (int i = 0; i < N; i++) send(W'($urandom), i == N - 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reload_out_valid", 64'(out_valid), 64'd1);
    check("ready_return", 64'(in_ready), 64'd1);
    drain("drain_backpressure");

    // Back-to-back windows with no input stalls.
    stalls = 0;
    hs_cycles.delete();
    for (int i = 0; i < 2 * N; i++) send(W'($urandom), (i % N) == N - 1, 0);
    drain("drain_b2b");
    check("b2b_stalls", 64'(stalls), 64'd0);
    check("b2b_windows", 64'(hs_cycles.size()), 64'd2);
    if (hs_cycles.size() == 2) check("b2b_spacing", 64'(hs_cycles[1] - hs_cycles[0]), 64'd49);

    // Early in_last at element 10, then a normal window.
    base = err_seen;
    for (int i = 0; i <= 10; i++) send(W'($urandom_range(1, 65535)), i == 10, 0);
    for (int i = 0; i < N; i++) send(W'($urandom), i == N - 1, 0);
    drain("drain_early_last");
`ifdef PACKER_ZERO_PAD_EN
    check("early_last_err", 64'(err_seen - base), 64'd0);
`else
    check("early_last_err", 64'(err_seen - base), 64'd1);
`endif
    // Missing in_last on the 49th element.
    base = err_seen;
    for (int i = 0; i < N; i++) send(W'($urandom), 1'b0, 0);
    drain("drain_missing_last");
    check("missing_last_err", 64'(err_seen - base), 64'd1);
    check("frame_err_total", 64'(err_seen), 64'(err_exp));

    // Reset mid-window at idx 30 with a sum_valid token in flight.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(W'($urandom), i == N - 1, 0);
    for (int i = 0; i < 30; i++) send(W'($urandom), 1'b0, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum_valid", 64'(sum_valid), 64'd0);
    check("midrst_out_flat_zero", 64'(out_flat == '0), 64'd1);
    exp_q.delete();
    sum_due.delete();
    cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(W'($urandom), i == N - 1, 0);
    drain("drain_after_rst");

    // Random input gaps, all 2.0.
    for (int i = 0; i < N; i++) send(16'h4000, i == N - 1, int'($urandom_range(0, 1)));
    drain("drain_gaps");
    // Random data windows with random gaps.
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < N; i++) send(W'($urandom), i == N - 1, int'($urandom_range(0, 2)));
    drain("drain_random");
    check("frame_err_final", 64'(err_seen), 64'(err_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_window_packer_49.md
Name: fp16_window_packer_49

Overview:
- Serial-to-parallel front end for the pipelined 49-input FP16 adder tree in the PE.
- Accepts one FP16 element per cycle over a valid/ready stream and assembles 49 elements (one 7x7 window).
- Presents the window on a flat 784-bit bus with an output valid/ready handshake.
- Tracks the tree's fixed pipeline latency and emits sum_valid aligned with the tree's final_sum.

Parameters:
- N_ELEM, 49: elements per window.
- DATA_W, 16: element width (FP16 bit pattern, not interpreted).
- TREE_LAT, 6: register stages between the tree input bus and final_sum.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  element payload.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final element of a window.
- in_ready  out  1  packer can accept an element this cycle.
- out_flat  out  DATA_W*N_ELEM  window; element k at [DATA_W*k+DATA_W-1 : DATA_W*k].
- out_valid  out  1  out_flat holds an unconsumed window.
- out_ready  in  1  consumer takes the window.
- sum_valid  out  1  tree final_sum corresponds to a handshaken window.
- frame_err  out  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Reset (async assert, sync release): idx=0, state=FILL, fill buffer=0, out_flat=0, out_valid=0, in_ready=0 during reset then 1, latency shift register=0, sum_valid=0, frame_err=0.
- Reset mid-window discards all partial data and in-flight sum_valid tokens.
- Accept: in_valid && in_ready. Accepting at idx<N_ELEM-1 writes slot idx and increments idx.
- Accept at idx==N_ELEM-1 completes the window.
  - Output slot free (out_valid==0 or out_ready==1 this cycle): next edge copies fill[0..47] plus in_data into out_flat, sets out_valid=1, idx=0, state stays FILL.
  - Otherwise: slot 48 is written, state goes to FULL.
- Latency: last element accepted at edge T; out_valid is high from cycle T+1. Streaming with out_ready=1 gives one window per 49 cycles, with no bubbles.
- FULL: in_ready=0. When the output slot frees (out_valid && out_ready, or out_valid==0), the next edge transfers fill to out_flat, out_valid=1, idx=0, state=FILL.
- out_flat is held stable while out_valid && !out_ready. out_valid clears on handshake unless a new window loads on the same edge; a back-to-back load keeps it high.
- sum_valid: TREE_LAT-deep shift register fed with (out_valid && out_ready). A handshake in cycle C gives sum_valid=1 in cycle C+TREE_LAT only.
- in_last rules:
  - in_last=1 at idx<N_ELEM-1: element is discarded, idx=0, frame_err pulses next cycle, no output.
  - in_last=0 at idx==N_ELEM-1: window completes normally, frame_err pulses.
- State machine: FILL and FULL only. FULL→FILL occurs solely on transfer.

Optional Feature:
- Macro PACKER_ZERO_PAD_EN.
- Defined: early in_last stores its element, zero-fills slots idx+1..48 (0x0000 = +0.0), completes the window per the normal transfer rules, and raises no frame_err. frame_err still fires for a missing in_last at idx 48.
- Undefined: early in_last follows the discard/error rule above.

Decomposition:
- Shared package pe_pkg holds:
  - constants PE_N_ELEM=49, PE_DATA_W=16, PE_TREE_LAT=6;
  - typedef fp16_t (16-bit);
  - state enum packer_state_e {FILL, FULL}.
- One natural sub-module: valid_delay_line, a parameterised TREE_LAT-deep shift register with async active-low clear, producing sum_valid.

Test Plan:
- Reset, then stream 0x3C00 (1.0) ×49 with out_ready=1 and in_last on the 49th → out_valid for 1 cycle; every slot 0x3C00; sum_valid exactly 6 cycles after the handshake; tree final_sum=0x5220 (49.0).
- Stream elements k=0..48 with value k+1 as FP16, out_ready=0 → out_valid held and out_flat stable; second window fills to FULL and in_ready=0; raise out_ready → second window loads next cycle, in_ready returns to 1.
- Two windows back-to-back, out_ready=1 → no input stalls; out_valid pulses 49 cycles apart; two sum_valid pulses 49 cycles apart.
- in_last at element 10:
  - without the macro → frame_err pulse, no out_valid, next 49 elements form a correct window;
  - with PACKER_ZERO_PAD_EN → window has slots 11..48 = 0x0000 and no frame_err.
- Deassert rst_n mid-window at idx=30 and while sum_valid tokens are in flight → all outputs 0 immediately, no stale sum_valid; fresh window is correct.
- Randomised in_valid gaps (50%), 0x4000 ×49 → window correct, sum 98.0 = 0x5620.
